// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request, shared-ALU and response bundle for the two-port ALU arbiter
interface alu_arbiter_if;
  logic       req0_valid;
  logic       req1_valid;
  logic [2:0] req0_func;
  logic [2:0] req1_func;
  logic [3:0] req0_a;
  logic [3:0] req1_a;
  logic       req0_ready;
  logic       req1_ready;
  logic [2:0] alu_func;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [7:0] alu_result;
  logic [7:0] acc;
  logic       resp_valid;
  logic       resp_id;
  logic [7:0] resp_data;
  logic       busy;
  logic [7:0] txn_count;
  modport master (
    output req0_valid, req1_valid, req0_func, req1_func, req0_a, req1_a, alu_result,
    input  req0_ready, req1_ready, alu_func, alu_a, alu_b, acc, resp_valid, resp_id,
           resp_data, busy, txn_count
  );
  modport slave (
    input  req0_valid, req1_valid, req0_func, req1_func, req0_a, req1_a, alu_result,
    output req0_ready, req1_ready, alu_func, alu_a, alu_b, acc, resp_valid, resp_id,
           resp_data, busy, txn_count
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one ALU and an 8-bit accumulator between two requesters
module alu_arbiter (
  input logic         clk,
  input logic         rst,
  alu_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  logic [1:0] state;
  logic       last_grant;
  logic       lat_id;
  logic [2:0] lat_func;
  logic [3:0] lat_a;
  logic [7:0] acc_q;
  logic [7:0] resp_data_q;
  logic [7:0] txn_q;
  logic       gnt0;
  logic       gnt1;
  logic [7:0] acc_next;
  // grant in IDLE only; on a tie the requester not granted last wins
  always_comb begin
    gnt0 = state == IDLE && bus.req0_valid && (!bus.req1_valid || last_grant);
    gnt1 = state == IDLE && bus.req1_valid && (!bus.req0_valid || !last_grant);
    acc_next = lat_func == 3'd6 ? acc_q : bus.alu_result;
  end
  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.alu_func   = state == EXEC ? lat_func : 3'd0;
  assign bus.alu_a      = state == EXEC ? lat_a : 4'd0;
  assign bus.alu_b      = acc_q[3:0];
  assign bus.acc        = acc_q;
  assign bus.resp_valid = state == RESP;
  assign bus.resp_id    = lat_id;
  assign bus.resp_data  = resp_data_q;
  assign bus.busy       = state != IDLE;
  assign bus.txn_count  = txn_q;
  // IDLE -> EXEC on transfer, EXEC -> RESP loads acc, RESP -> IDLE counts the transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      lat_id      <= 1'b0;
      lat_func    <= 3'd0;
      lat_a       <= 4'd0;
      acc_q       <= 8'd0;
      resp_data_q <= 8'd0;
      txn_q       <= 8'd0;
    end else if (gnt0 || gnt1) begin
      state      <= EXEC;
      lat_func   <= gnt1 ? bus.req1_func : bus.req0_func;
      lat_a      <= gnt1 ? bus.req1_a : bus.req0_a;
      lat_id     <= gnt1;
      last_grant <= gnt1;
    end else if (state == EXEC) begin
      state       <= RESP;
      acc_q       <= acc_next;
      resp_data_q <= acc_next;
    end else if (state == RESP) begin
      state <= IDLE;
      txn_q <= txn_q + 8'd1;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: vector table, directed sequences and random traffic checked against a transaction model
module tb_alu_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  alu_arbiter_if bus ();
  alu_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic       v0;
    logic       v1;
    logic [2:0] f0;
    logic [2:0] f1;
    logic [3:0] a0;
    logic [3:0] a1;
    logic       id;
    logic [7:0] data;
  } vec_t;
  vec_t tbl [7];
  logic       m_busy_phase_exec;
  int         m_phase;
  logic       m_last;
  logic       m_id;
  logic [2:0] m_f;
  logic [3:0] m_a;
  logic [7:0] m_acc;
  logic [7:0] m_rd;
  logic [7:0] m_cnt;
  function automatic logic [7:0] alu_model(input logic [2:0] f, input logic [3:0] a, input logic [3:0] b);
    case (f)
      3'd0: alu_model = {4'h0, a & b};
      3'd1: alu_model = {4'h0, a} + {4'h0, b};
      3'd2: alu_model = {4'h0, a ^ b};
      3'd3: alu_model = (|a || |b) ? 8'h0F : 8'h00;
      3'd4: alu_model = {a, b};
      3'd5: alu_model = {4'h0, a} * {4'h0, b};
      3'd6: alu_model = 8'hEE;
      default: alu_model = ~{a, b};
    endcase
  endfunction
  always_comb bus.alu_result = alu_model(bus.alu_func, bus.alu_a, bus.alu_b);
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_phase = 0;
    m_last  = 1'b1;
    m_id    = 1'b0;
    m_f     = 3'd0;
    m_a     = 4'd0;
    m_acc   = 8'd0;
    m_rd    = 8'd0;
    m_cnt   = 8'd0;
  endtask
  task automatic drive(input logic v0, input logic v1, input logic [2:0] f0, input logic [2:0] f1,
                       input logic [3:0] a0, input logic [3:0] a1);
    bus.req0_valid = v0;
    bus.req1_valid = v1;
    bus.req0_func  = f0;
    bus.req1_func  = f1;
    bus.req0_a     = a0;
    bus.req1_a     = a1;
  endtask
  task automatic step(input logic v0, input logic v1, input logic [2:0] f0, input logic [2:0] f1,
                      input logic [3:0] a0, input logic [3:0] a1);
    logic g;
    logic w;
    logic [7:0] nxt;
    drive(v0, v1, f0, f1, a0, a1);
    #1;
    g = m_phase == 0 && (v0 || v1);
    w = (v0 && v1) ? ~m_last : v1;
    chk("ready0", 32'(bus.req0_ready), 32'(g && !w));
    chk("ready1", 32'(bus.req1_ready), 32'(g && w));
    chk("busy", 32'(bus.busy), 32'(m_phase != 0));
    chk("alu_func", 32'(bus.alu_func), 32'(m_phase == 1 ? m_f : 3'd0));
    chk("alu_a", 32'(bus.alu_a), 32'(m_phase == 1 ? m_a : 4'd0));
    chk("alu_b", 32'(bus.alu_b), 32'(m_acc[3:0]));
    chk("acc", 32'(bus.acc), 32'(m_acc));
    chk("resp_valid", 32'(bus.resp_valid), 32'(m_phase == 2));
    if (m_phase == 2) chk("resp_id", 32'(bus.resp_id), 32'(m_id));
    chk("resp_data", 32'(bus.resp_data), 32'(m_rd));
    chk("txn_count", 32'(bus.txn_count), 32'(m_cnt));
    if (m_phase == 0) begin
      if (g) begin
        m_f     = w ? f1 : f0;
        m_a     = w ? a1 : a0;
        m_id    = w;
        m_last  = w;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      nxt     = m_f == 3'd6 ? m_acc : alu_model(m_f, m_a, m_acc[3:0]);
      m_acc   = nxt;
      m_rd    = nxt;
      m_phase = 2;
    end else begin
      m_cnt   = m_cnt + 8'd1;
      m_phase = 0;
    end
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 3'd0, 3'd0, 4'd0, 4'd0);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_acc", 32'(bus.acc), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_data", 32'(bus.resp_data), 32'd0);
    chk("rst_resp_id", 32'(bus.resp_id), 32'd0);
    chk("rst_txn", 32'(bus.txn_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask
  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    drive(1'b0, 1'b0, 3'd0, 3'd0, 4'd0, 4'd0);
    model_reset();
    tbl[0] = '{1'b1, 1'b0, 3'd1, 3'd0, 4'd3, 4'd0, 1'b0, 8'h03};
    tbl[1] = '{1'b1, 1'b1, 3'd1, 3'd1, 4'd2, 4'd5, 1'b1, 8'h08};
    tbl[2] = '{1'b1, 1'b1, 3'd3, 3'd1, 4'd0, 4'd1, 1'b0, 8'h0F};
    tbl[3] = '{1'b0, 1'b1, 3'd0, 3'd6, 4'd0, 4'd9, 1'b1, 8'h0F};
    tbl[4] = '{1'b1, 1'b1, 3'd1, 3'd1, 4'd1, 4'd2, 1'b0, 8'h10};
    tbl[5] = '{1'b1, 1'b0, 3'd3, 3'd0, 4'd0, 4'd0, 1'b0, 8'h00};
    tbl[6] = '{1'b1, 1'b1, 3'd1, 3'd1, 4'd4, 4'd6, 1'b1, 8'h06};
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].v0, tbl[i].v1, tbl[i].f0, tbl[i].f1, tbl[i].a0, tbl[i].a1);
      step(1'b0, 1'b0, 3'd0, 3'd0, 4'd0, 4'd0);
      chk("tbl_resp_valid", 32'(bus.resp_valid), 32'd1);
      chk("tbl_resp_id", 32'(bus.resp_id), 32'(tbl[i].id));
      chk("tbl_resp_data", 32'(bus.resp_data), 32'(tbl[i].data));
      step(1'b0, 1'b0, 3'd0, 3'd0, 4'd0, 4'd0);
      if (i == 0) chk("first_txn_count", 32'(bus.txn_count), 32'd1);
    end
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b1, 3'd1, 3'd1, 4'd2, 4'd5);
      if (k == 1) chk("pair_acc0", 32'(bus.acc), 32'h02);
      if (k == 4) chk("pair_acc1", 32'(bus.acc), 32'h07);
    end
    step(1'b0, 1'b1, 3'd0, 3'd6, 4'd0, 4'd9);
    step(1'b0, 1'b0, 3'd0, 3'd0, 4'd0, 4'd0);
    chk("hold_resp_data", 32'(bus.resp_data), 32'h07);
    chk("hold_acc", 32'(bus.acc), 32'h07);
    step(1'b0, 1'b0, 3'd0, 3'd0, 4'd0, 4'd0);
    for (int k = 0; k < 18; k++) step(1'b1, 1'b1, 3'd1, 3'd1, 4'd2, 4'd5);
    step(1'b1, 1'b0, 3'd1, 3'd0, 4'd4, 4'd0);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_acc", 32'(bus.acc), 32'd0);
    chk("abort_txn", 32'(bus.txn_count), 32'd0);
    chk("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 3'd0, 3'd0, 4'd0, 4'd0);
    step(1'b1, 1'b0, 3'd1, 3'd0, 4'd3, 4'd0);
    step(1'b0, 1'b0, 3'd0, 3'd0, 4'd0, 4'd0);
    chk("after_abort_data", 32'(bus.resp_data), 32'h03);
    step(1'b0, 1'b0, 3'd0, 3'd0, 4'd0, 4'd0);
    chk("after_abort_txn", 32'(bus.txn_count), 32'd1);
    do_reset();
    for (int k = 0; k < 768; k++) step(1'b1, 1'b1, 3'($urandom_range(7)), 3'($urandom_range(7)),
                                         4'($urandom_range(15)), 4'($urandom_range(15)));
    chk("wrap_txn", 32'(bus.txn_count), 32'd0);
    for (int k = 0; k < 1500; k++) step(1'($urandom_range(1)), 1'($urandom_range(1)),
                                          3'($urandom_range(7)), 3'($urandom_range(7)),
                                          4'($urandom_range(15)), 4'($urandom_range(15)));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
